// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing and receiver state encoding.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 104;  // 12 MHz / 115200 baud

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for a single asynchronous input.
module uart_sync2 #(
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= INIT;
      q    <= INIT;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled mid-bit sampling, one-entry holding register
// with valid/ready, single-cycle framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int CNT_W        = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e        state, state_nxt;
  logic [CNT_W-1:0] baud_cnt, baud_nxt;
  logic [2:0]       bit_cnt, bit_nxt;
  logic [7:0]       shift_reg, shift_nxt;
  logic             rxd_s;
  logic             stop_ok, stop_bad;

  uart_sync2 #(.INIT(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt + 1'b1;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_reg;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_nxt = '0;
        if (!rxd_s) state_nxt = ST_START;
      end
      ST_START: begin
        if (baud_cnt == HALF_M1) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          // A start bit that is high again at mid-bit was only a glitch
          state_nxt = rxd_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_cnt == FULL_M1) begin
          baud_nxt  = '0;
          shift_nxt = {rxd_s, shift_reg[7:1]};
          if (bit_cnt == 3'd7) begin
            bit_nxt   = '0;
            state_nxt = ST_STOP;
          end else begin
            bit_nxt   = bit_cnt + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (baud_cnt == FULL_M1) begin
          baud_nxt  = '0;
          stop_ok   = rxd_s;
          stop_bad  = !rxd_s;
          state_nxt = rxd_s ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        // Wait out a held-low line so it cannot look like a new start bit
        baud_nxt = '0;
        if (rxd_s) state_nxt = ST_IDLE;
      end
      default: begin
        baud_nxt  = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      // A byte consumed in the same cycle frees the slot for the new one
      if (stop_ok && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else begin
        if (stop_ok) overrun <= 1'b1;
        if (rx_valid && rx_ready) rx_valid <= 1'b0;
      end
    end
  end

  assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized traffic
// against a frame-level model (byte queue and flag counts).
module tb_uart_rx;

  localparam int CPB = 104;
  localparam int LAT = CPB/2 + 9*CPB + 3;  // pin start edge to rx_valid

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(12)) u_uart_rx (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  logic [7:0] acc_q[$];
  int rise_cyc = -1, ferr_n = 0, ferr_hi = 0, ovr_n = 0, ovr_hi = 0;
  int both_n = 0, busy_n = 0;
  logic pv = 1'b0, pf = 1'b0, po = 1'b0;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) acc_q.push_back(rx_data);
    if (rx_valid && !pv) rise_cyc <= cyc;
    if (frame_err && !pf) ferr_n <= ferr_n + 1;
    if (frame_err) ferr_hi <= ferr_hi + 1;
    if (overrun && !po) ovr_n <= ovr_n + 1;
    if (overrun) ovr_hi <= ovr_hi + 1;
    if (frame_err && overrun) both_n <= both_n + 1;
    if (rx_busy) busy_n <= busy_n + 1;
    pv <= rx_valid;
    pf <= frame_err;
    po <= overrun;
  end

  // Reference model: bytes that must reach the consumer, and expected flags
  logic [7:0] exp_q[$];
  int exp_ferr = 0, exp_ovr = 0;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  initial begin
    int t0, r0, b0, f0, o0;
    rst = 1'b1; rxd = 1'b1; rx_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("reset_data",  rx_data,   8'h00);
    chk("reset_valid", rx_valid,  1'b0);
    chk("reset_ferr",  frame_err, 1'b0);
    chk("reset_ovr",   overrun,   1'b0);
    chk("reset_busy",  rx_busy,   1'b0);
    tick(10);

    // Single byte, consumer stalled: check latency and hold
    t0 = cyc;
    send_frame(8'h41, 1'b1);
    chk("lat_41",   rise_cyc - t0, LAT);
    chk("data_41",  rx_data, 8'h41);
    chk("valid_41", rx_valid, 1'b1);
    tick(50);
    chk("hold_41",  rx_valid, 1'b1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    chk("drop_41",  rx_valid, 1'b0);
    exp_q.push_back(8'h41);
    tick(20);

    // Short low glitch: START entered then aborted
    r0 = rise_cyc; b0 = busy_n;
    rxd = 1'b0;
    tick(20);
    rxd = 1'b1;
    tick(CPB);
    chk("glitch_busy_seen", (busy_n > b0) ? 1 : 0, 1);
    chk("glitch_busy_end",  rx_busy, 1'b0);
    chk("glitch_novalid",   rise_cyc, r0);

    // Framing error, held break, then a good frame
    rx_ready = 1'b1;
    f0 = ferr_n;
    send_frame(8'h55, 1'b0);
    repeat (3) drive_bit(1'b0);
    chk("break_busy", rx_busy, 1'b1);
    chk("ferr_once",  ferr_n - f0, 1);
    exp_ferr++;
    drive_bit(1'b1);
    drive_bit(1'b1);
    send_frame(8'h42, 1'b1);
    exp_q.push_back(8'h42);
    tick(CPB);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    rx_ready = 1'b0;
    tick(CPB);

    // Overrun with consumer stalled
    o0 = ovr_n;
    send_frame(8'h12, 1'b1);
    drive_bit(1'b1);
    send_frame(8'h34, 1'b1);
    chk("ovr_once",  ovr_n - o0, 1);
    chk("ovr_data",  rx_data, 8'h12);
    chk("ovr_valid", rx_valid, 1'b1);
    exp_ovr++;
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    exp_q.push_back(8'h12);
    tick(CPB);

    // Consume exactly on the second stop sample: no overrun, new byte loads
    o0 = ovr_n;
    send_frame(8'h12, 1'b1);
    drive_bit(1'b1);
    fork
      send_frame(8'h34, 1'b1);
      begin
        tick(LAT - 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    chk("edge_noovr", ovr_n - o0, 0);
    chk("edge_data",  rx_data, 8'h34);
    chk("edge_valid", rx_valid, 1'b1);
    exp_q.push_back(8'h12);
    tick(CPB);

    // Reset in the middle of data bit 4, with a byte still held
    drive_bit(1'b0);
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
    rxd = 1'b1;
    tick(CPB/2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mrst_valid", rx_valid, 1'b0);
    chk("mrst_data",  rx_data,  8'h00);
    chk("mrst_busy",  rx_busy,  1'b0);
    tick(2*CPB);
    chk("mrst_idle",  rx_busy,  1'b0);
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    tick(CPB);

    // Randomized traffic, consumer always ready
    for (int f = 0; f < 15; f++) begin
      logic [7:0] d;
      logic bad;
      d   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 4) == 0);
      send_frame(d, !bad);
      if (bad) begin
        repeat ($urandom_range(0, 2)) drive_bit(1'b0);
        drive_bit(1'b1);
        exp_ferr++;
      end else begin
        exp_q.push_back(d);
      end
      repeat ($urandom_range(0, 2)) drive_bit(1'b1);
      rxd = 1'b1;
      tick($urandom_range(0, CPB-1));
    end
    tick(2*CPB);

    chk("acc_count", acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
      chk($sformatf("acc[%0d]", i), acc_q[i], exp_q[i]);
    chk("ferr_total",   ferr_n,  exp_ferr);
    chk("ovr_total",    ovr_n,   exp_ovr);
    chk("ferr_width",   ferr_hi, ferr_n);
    chk("ovr_width",    ovr_hi,  ovr_n);
    chk("flags_apart",  both_n,  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
